// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction decode and control FSM downstream of fetch
//
// Purpose:
//   Sequences each instruction through FETCH -> DECODE (-> EXEC_LONG) and
//   decodes the datapath control lines combinationally from the current
//   state, the latched opcode/operand nibbles and the registered ALU flags.
//   One-byte instructions take 2 cycles, two-byte (address) ones take 3.
//
// Optional feature:
//   CONTROL_SEQUENCER_HALT_EN - opcode F enters a HALT state left only by
//   reset. Without it, opcode F is a NOP and `halted` is tied low.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-low reset
//   instr          in   4   opcode nibble from the fetch register
//   operand        in   4   operand nibble from the fetch register
//   programByte    in   8   ROM byte at the current PC (argument byte)
//   carry, zero    in   1   registered ALU flags
//   enableCounter  out  1   PC increment
//   enableFetch    out  1   fetch register load
//   load           out  1   PC parallel load (jump taken)
//   valueLoad      out  12  {operand, argReg}: jump target / RAM address
//   aluSel         out  3   000 pass-B, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOR
//   accEn          out  1   accumulator write enable
//   flagsEn        out  1   flag register write enable
//   busOperand     out  1   drive operand onto the data bus
//   ramOe, ramWe   out  1   RAM read / write
//   outEn          out  1   output port latch
//   halted         out  1   high while in HALT

module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  instr,
  input  logic [3:0]  operand,
  input  logic [7:0]  programByte,
  input  logic        carry,
  input  logic        zero,
  output logic        enableCounter,
  output logic        enableFetch,
  output logic        load,
  output logic [11:0] valueLoad,
  output logic [2:0]  aluSel,
  output logic        accEn,
  output logic        flagsEn,
  output logic        busOperand,
  output logic        ramOe,
  output logic        ramWe,
  output logic        outEn,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXEC_LONG = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_NORI = 4'h6;
  localparam logic [3:0] OP_CMPI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JNC  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;

  state_t     r_state;
  logic [7:0] r_arg_reg;

  logic w_two_byte;
  logic w_jump_taken;

  // The fetch register only reloads in FETCH, so instr/operand stay valid
  // through DECODE and EXEC_LONG and need no local copy.
  assign w_two_byte = (instr >= OP_LD) && (instr <= OP_JNZ);

  // Flags are sampled live in EXEC_LONG, so a flag write from the preceding
  // DECODE of an earlier instruction is already visible here.
  always_comb begin
    w_jump_taken = 1'b0;
    case (instr)
      OP_JC:   w_jump_taken = carry;
      OP_JNC:  w_jump_taken = ~carry;
      OP_JZ:   w_jump_taken = zero;
      OP_JNZ:  w_jump_taken = ~zero;
      default: w_jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_arg_reg <= 8'h00;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_two_byte) begin
            r_arg_reg <= programByte;
            r_state   <= S_EXEC_LONG;
          end else if (instr == OP_HLT) begin
`ifdef CONTROL_SEQUENCER_HALT_EN
            r_state <= S_HALT;
`else
            r_state <= S_FETCH;
`endif
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC_LONG: r_state <= S_FETCH;
        S_HALT: begin
`ifdef CONTROL_SEQUENCER_HALT_EN
          r_state <= S_HALT;
`else
          r_state <= S_FETCH;
`endif
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // All control lines are gated by reset so an abort (e.g. mid-store)
  // drops every enable in the same cycle reset is asserted.
  always_comb begin
    enableCounter = 1'b0;
    enableFetch   = 1'b0;
    load          = 1'b0;
    aluSel        = ALU_PASS;
    accEn         = 1'b0;
    flagsEn       = 1'b0;
    busOperand    = 1'b0;
    ramOe         = 1'b0;
    ramWe         = 1'b0;
    outEn         = 1'b0;
    halted        = 1'b0;
    valueLoad     = reset ? {operand, r_arg_reg} : 12'h000;

    if (reset) begin
      case (r_state)
        S_FETCH: begin
          enableFetch   = 1'b1;
          enableCounter = 1'b1;
        end
        S_DECODE: begin
          case (instr)
            OP_LDI: begin
              busOperand = 1'b1;
              aluSel     = ALU_PASS;
              accEn      = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_NORI: begin
              busOperand = 1'b1;
              accEn      = 1'b1;
              flagsEn    = 1'b1;
              case (instr)
                OP_ADDI: aluSel = ALU_ADD;
                OP_SUBI: aluSel = ALU_SUB;
                OP_ANDI: aluSel = ALU_AND;
                OP_ORI:  aluSel = ALU_OR;
                default: aluSel = ALU_NOR;
              endcase
            end
            OP_CMPI: begin
              busOperand = 1'b1;
              aluSel     = ALU_SUB;
              flagsEn    = 1'b1;
            end
            OP_OUT: outEn = 1'b1;
            // Skip the argument byte; it is captured into r_arg_reg here.
            OP_LD, OP_ST, OP_JC, OP_JNC, OP_JZ, OP_JNZ: enableCounter = 1'b1;
            default: ;
          endcase
        end
        S_EXEC_LONG: begin
          case (instr)
            OP_LD: begin
              ramOe  = 1'b1;
              aluSel = ALU_PASS;
              accEn  = 1'b1;
            end
            OP_ST:   ramWe = 1'b1;
            default: load  = w_jump_taken;
          endcase
        end
        S_HALT: begin
`ifdef CONTROL_SEQUENCER_HALT_EN
          halted = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic [7:0]  programByte;
  logic        carry = 1'b0;
  logic        zero = 1'b0;
  logic        enableCounter, enableFetch, load;
  logic [11:0] valueLoad;
  logic [2:0]  aluSel;
  logic        accEn, flagsEn, busOperand, ramOe, ramWe, outEn, halted;

  always #5 clk = ~clk;

  // Surrounding system: program ROM, PC and fetch register.
  logic [7:0]  rom [0:4095];
  logic [11:0] env_pc = 12'h000;
  logic [11:0] pc_init = 12'h000;
  logic [7:0]  fetch_reg = 8'h00;

  assign instr       = fetch_reg[7:4];
  assign operand     = fetch_reg[3:0];
  assign programByte = rom[env_pc];

  always @(posedge clk) begin
    if (!reset) begin
      env_pc <= pc_init;
    end else begin
      if (load) env_pc <= valueLoad;
      else if (enableCounter) env_pc <= env_pc + 12'd1;
      if (enableFetch) fetch_reg <= rom[env_pc];
    end
  end

  control_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .operand(operand),
    .programByte(programByte), .carry(carry), .zero(zero),
    .enableCounter(enableCounter), .enableFetch(enableFetch), .load(load),
    .valueLoad(valueLoad), .aluSel(aluSel), .accEn(accEn), .flagsEn(flagsEn),
    .busOperand(busOperand), .ramOe(ramOe), .ramWe(ramWe), .outEn(outEn),
    .halted(halted)
  );

  logic [24:0] w_act;
  assign w_act = {enableCounter, enableFetch, load, valueLoad, aluSel,
                  accEn, flagsEn, busOperand, ramOe, ramWe, outEn, halted};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (instruction level).
  logic [11:0] m_pc  = 12'h000;
  logic [7:0]  m_arg = 8'h00;
  logic [3:0]  m_od  = 4'h0;

  function automatic logic [24:0] mk(input logic ec, input logic ef, input logic ld,
                                     input logic [11:0] vl, input logic [2:0] alu,
                                     input logic acc, input logic fl, input logic bus,
                                     input logic oe, input logic we, input logic oute,
                                     input logic h);
    return {ec, ef, ld, vl, alu, acc, fl, bus, oe, we, oute, h};
  endfunction

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s pc=%h observed=%h expected=%h", tag, m_pc, obs, exp);
    end
  endtask

  // One clock cycle: inputs driven just after the rising edge, outputs
  // sampled at the falling edge.
  task automatic step(input bit rnd, input logic c, input logic z);
    @(posedge clk);
    #1;
    reset = 1'b1;
    carry = rnd ? 1'($urandom_range(1)) : c;
    zero  = rnd ? 1'($urandom_range(1)) : z;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic [11:0] p);
    pc_init = p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", w_act, 25'h0);
    end
    m_pc  = p;
    m_arg = 8'h00;
  endtask

  // Execute the instruction at m_pc, checking every cycle.
  task automatic exec_one(input bit rnd, input logic c, input logic z);
    logic [7:0]  b;
    logic [3:0]  op, od;
    logic        taken;
    logic [24:0] e;
    b  = rom[m_pc];
    op = b[7:4];
    od = b[3:0];

    step(rnd, c, z);
    check("pc_at_fetch", {13'b0, env_pc}, {13'b0, m_pc});
    check("fetch", w_act, mk(1, 1, 0, {m_od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0));
    m_od = od;

    step(rnd, c, z);
    if (op >= 4'h8 && op <= 4'hD) begin
      check("decode_long", w_act, mk(1, 0, 0, {od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0));
      m_arg = rom[m_pc + 12'd1];
      step(rnd, c, z);
      taken = 1'b0;
      e = mk(0, 0, 0, {od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0);
      case (op)
        4'h8: e = mk(0, 0, 0, {od, m_arg}, 3'b000, 1, 0, 0, 1, 0, 0, 0);
        4'h9: e = mk(0, 0, 0, {od, m_arg}, 3'b000, 0, 0, 0, 0, 1, 0, 0);
        4'hA: taken = carry;
        4'hB: taken = !carry;
        4'hC: taken = zero;
        default: taken = !zero;
      endcase
      if (op >= 4'hA) e = mk(0, 0, taken, {od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0);
      check("exec_long", w_act, e);
      m_pc = taken ? {od, m_arg} : m_pc + 12'd2;
    end else begin
      case (op)
        4'h1:                   e = mk(0, 0, 0, {od, m_arg}, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
                                e = mk(0, 0, 0, {od, m_arg}, 3'(op - 4'h1), 1, 1, 1, 0, 0, 0, 0);
        4'h7:                   e = mk(0, 0, 0, {od, m_arg}, 3'b010, 0, 1, 1, 0, 0, 0, 0);
        4'hE:                   e = mk(0, 0, 0, {od, m_arg}, 0, 0, 0, 0, 0, 0, 1, 0);
        default:                e = mk(0, 0, 0, {od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      check("decode_short", w_act, e);
      m_pc = m_pc + 12'd1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

    // Reset asserted during DECODE of ADDI.
    rom[12'h005] = 8'h23;
    do_reset(2, 12'h005);
    step(0, 0, 0);
    check("fetch_before_abort", w_act, mk(1, 1, 0, {m_od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 0));
    m_od = 4'h3;
    do_reset(3, 12'h005);
    exec_one(0, 0, 0);

    // LDI 5 ; ADDI 3
    rom[12'h000] = 8'h15;
    rom[12'h001] = 8'h23;
    do_reset(1, 12'h000);
    exec_one(0, 0, 0);
    exec_one(0, 0, 0);

    // JC 0x140 taken, then not taken.
    rom[12'h010] = 8'hA1;
    rom[12'h011] = 8'h40;
    rom[12'h140] = 8'h00;
    rom[12'h012] = 8'h00;
    do_reset(1, 12'h010);
    exec_one(0, 1, 0);
    exec_one(0, 1, 0);
    do_reset(1, 12'h010);
    exec_one(0, 0, 0);
    exec_one(0, 0, 0);

    // ST 0x321 ; LD 0x321
    rom[12'h020] = 8'h93;
    rom[12'h021] = 8'h21;
    rom[12'h022] = 8'h83;
    rom[12'h023] = 8'h21;
    rom[12'h024] = 8'hE0;
    do_reset(1, 12'h020);
    exec_one(0, 0, 0);
    exec_one(0, 0, 0);
    exec_one(0, 0, 0);

    // JZ at 0xFFF with argument wrapped to 0x000.
    rom[12'hFFF] = 8'hC0;
    rom[12'h000] = 8'h7F;
    rom[12'h07F] = 8'h00;
    do_reset(1, 12'hFFF);
    exec_one(0, 0, 1);
    exec_one(0, 0, 1);

    // Opcode F
    rom[12'h040] = 8'hF0;
    rom[12'h041] = 8'h15;
    do_reset(1, 12'h040);
    exec_one(0, 0, 0);
`ifdef CONTROL_SEQUENCER_HALT_EN
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      check("halt_hold", w_act, mk(0, 0, 0, {m_od, m_arg}, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    do_reset(1, 12'h041);
    exec_one(0, 0, 0);
`else
    exec_one(0, 0, 0);
`endif

    // Randomized program with random flags.
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
`ifdef CONTROL_SEQUENCER_HALT_EN
      if (rom[i][7:4] == 4'hF) rom[i] = {4'hE, rom[i][3:0]};
`endif
    end
    do_reset(2, 12'($urandom));
    for (int i = 0; i < 120; i++) exec_one(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Instruction decode and control FSM directly downstream of the fetch stage. Consumes the latched `instr`/`operand` nibbles and the raw `programByte` from program ROM, and drives the program counter and fetch-register enables plus the datapath control lines (ALU, accumulator, flags, RAM, output port). One-byte instructions take 2 cycles; two-byte (address) instructions take 3.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `instr`  in  4  opcode from fetch register
- `operand`  in  4  operand nibble from fetch register
- `programByte`  in  8  ROM byte at current PC; used as the second byte of address instructions
- `carry`, `zero`  in  1 each  registered ALU flags
- `enableCounter`  out  1  PC increment
- `enableFetch`  out  1  fetch register load
- `load`  out  1  PC parallel load (jump taken)
- `valueLoad`  out  12  jump target / RAM address = {operand, argReg}
- `aluSel`  out  3  000 pass-B, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOR
- `accEn`, `flagsEn`  out  1 each  accumulator / flag register write enables
- `busOperand`  out  1  drive `operand` onto the data bus
- `ramOe`, `ramWe`  out  1 each  RAM read / write
- `outEn`  out  1  output port latch
- `halted`  out  1  high in HALT

## Operation
- States: FETCH, DECODE, EXEC_LONG, HALT. Outputs are decoded combinationally from state, `instr`, `operand`, and the flags.
- FETCH: `enableFetch`=1, `enableCounter`=1. Next state: DECODE.
- DECODE, one-byte opcodes. Each executes in this cycle, then goes to FETCH.
  - 0 NOP: no outputs asserted.
  - 1 LDI: busOperand, aluSel=000, accEn.
  - 2 ADDI, 3 SUBI, 4 ANDI, 5 ORI, 6 NORI: busOperand, aluSel=001..101 respectively, accEn, flagsEn.
  - 7 CMPI: busOperand, aluSel=010, flagsEn; no accEn.
  - E OUT: outEn.
  - F: see Configuration.
- DECODE, two-byte opcodes 8 LD, 9 ST, A JC, B JNC, C JZ, D JNZ:
  - `argReg` <= `programByte`.
  - `enableCounter`=1 so the PC skips the argument byte.
  - Next state: EXEC_LONG.
- EXEC_LONG: `valueLoad`={operand, argReg}.
  - LD: ramOe, aluSel=000, accEn.
  - ST: ramWe.
  - Jumps: `load`=1 when the condition holds (JC: carry, JNC: !carry, JZ: zero, JNZ: !zero). Flags are sampled in this cycle.
  - Next state: FETCH.
- `valueLoad` equals {operand, argReg} in every state; it is only meaningful in EXEC_LONG.
- `load` and `enableCounter` are never high in the same cycle.
- `enableFetch` is high only in FETCH.

## Timing
- Reset (`reset`=0 at a rising edge): state <= FETCH, `argReg` <= 0.
- While `reset` is low, every control output is forced to 0, including `halted`, and `valueLoad`=0.
- First FETCH cycle is the first cycle after `reset` returns high.
- Reset mid-instruction, including from EXEC_LONG or HALT, aborts immediately. No partial write is retained: `ramWe` drops in the same cycle.
- Instruction latency:
  - One-byte: 2 cycles, FETCH then DECODE.
  - Two-byte: 3 cycles.
  - Taken jump: the PC holds the target after the EXEC_LONG edge; the next FETCH reads the target byte.
- PC wraps 0xFFF -> 0x000 without sequencer involvement. A two-byte instruction at 0xFFF takes its argument from 0x000.
- Flag updates in a DECODE cycle are visible to a conditional jump no earlier than that jump's EXEC_LONG cycle.

## Configuration
- `CONTROL_SEQUENCER_HALT_EN` defined:
  - Opcode F in DECODE enters HALT.
  - HALT asserts only `halted`=1, with all enables 0.
  - HALT is left only by reset.
- Macro undefined:
  - Opcode F decodes as NOP and returns to FETCH.
  - HALT is unreachable and `halted` is tied 0.

## Test plan
- Reset held low 3 cycles during DECODE of ADDI -> all outputs 0; first cycle after release is FETCH (`enableFetch`=1, `enableCounter`=1).
- ROM 0x000: 0x15 (LDI 5), 0x23 (ADDI 3) -> cycles 1/3 are FETCH; cycle 2 busOperand+accEn with aluSel=000; cycle 4 aluSel=001 with accEn+flagsEn; 4 cycles total.
- ROM 0x010: 0xA1, 0x40 (JC 0x140), carry=1 -> DECODE captures argReg=0x40 with enableCounter=1; EXEC_LONG load=1, valueLoad=0x140; next FETCH reads from 0x140. Repeat with carry=0 -> load=0; next fetch from 0x012.
- ROM: 0x93, 0x21 (ST 0x321) -> EXEC_LONG ramWe=1 for exactly one cycle with valueLoad=0x321. LD 0x321 -> ramOe+accEn one cycle, aluSel=000.
- Two-byte instruction at PC 0xFFF (0xC0), byte at 0x000 = 0x7F, zero=1 -> valueLoad=0x07F, load=1.
- Opcode 0xF0 -> with `CONTROL_SEQUENCER_HALT_EN`: halted=1 and no enables for 10 cycles, cleared by reset. Without the macro: behaves as NOP, next fetch proceeds.
